// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared constants, state encoding and round-robin search for rr_decode_arbiter
package rr_arb_pkg;
  localparam int N_REQ = 16;
  localparam int IDX_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, GAP = 2'd2} state_t;
  // First set bit scanning last+1, last+2, ... modulo N_REQ; descending loop lets the nearest offset win.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] k;
    rr_pick = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      k = last + IDX_W'(i);
      if (req[k]) rr_pick = k;
    end
  endfunction
endpackage

// File: rtl/onehot_dec16.sv
// onehot_dec16: 4-to-16 one-hot decode gated by enable
module onehot_dec16 (
  input  logic [3:0]  i_idx,
  input  logic        i_en,
  output logic [15:0] o_onehot
);
  assign o_onehot = i_en ? 16'(1) << i_idx : '0;
endmodule

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: 16-way round-robin arbiter with release, withdrawal and hold-time preemption
module rr_decode_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_release,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_en,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_busy
);
  state_t           r_state, w_nstate;
  logic [IDX_W-1:0] r_idx, r_last, w_nidx, w_nlast;
  logic [CNT_W-1:0] r_cnt, w_ncnt;
  logic             w_exit;
  always_comb begin
    w_exit   = i_release | ~i_req[r_idx] | (r_cnt == CNT_W'(MAX_HOLD - 1));
    w_nstate = r_state;
    w_nidx   = r_idx;
    w_nlast  = r_last;
    w_ncnt   = r_cnt;
    case (r_state)
      IDLE: if (|i_req) begin
        w_nstate = OWN;
        w_nidx   = rr_pick(i_req, r_last);
        w_ncnt   = '0;
      end
      OWN: begin
        w_ncnt = r_cnt + CNT_W'(1);
        if (w_exit) begin
          w_nstate = GAP;
          w_nlast  = r_idx;
        end
      end
      default: w_nstate = IDLE;
    endcase
  end
  // last_idx=15 at reset makes index 0 the first candidate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_last  <= IDX_W'(N_REQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_idx   <= w_nidx;
      r_last  <= w_nlast;
      r_cnt   <= w_ncnt;
    end
  end
  assign o_grant_idx = r_idx;
  assign o_grant_en  = (r_state == OWN);
  assign o_busy      = (r_state != IDLE);
  onehot_dec16 u_dec (
    .i_idx   (r_idx),
    .i_en    (o_grant_en),
    .o_onehot(o_grant)
  );
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb_rr_decode_arbiter: directed plan plus random traffic checked against a behavioural owner/gap model
module tb_rr_decode_arbiter;
  localparam int MAX_HOLD = 8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_release = 1'b0;
  logic [15:0] i_req = '0;
  logic [3:0]  o_grant_idx;
  logic        o_grant_en;
  logic [15:0] o_grant;
  logic        o_busy;
  int n_chk = 0;
  int n_fail = 0;
  int m_owner = -1;
  int m_held = 0;
  int m_last = 15;
  int m_idx = 0;
  bit m_gap = 1'b0;
  always #5 clk = ~clk;
  rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_release  (i_release),
    .o_grant_idx(o_grant_idx),
    .o_grant_en (o_grant_en),
    .o_grant    (o_grant),
    .o_busy     (o_busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 15;
    m_idx   = 0;
    m_gap   = 1'b0;
  endtask
  // One clock edge of the reference: an owner, a single dead cycle, or an idle search.
  task automatic m_edge();
    bit found;
    int c;
    if (m_owner >= 0) begin
      m_held++;
      if (i_release || !i_req[m_owner] || m_held == MAX_HOLD) begin
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (i_req != 0) begin
      found = 1'b0;
      for (int off = 1; off <= 16; off++) begin
        c = (m_last + off) % 16;
        if (!found && i_req[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_idx   = c;
          m_held  = 0;
        end
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    chk("en", 32'(o_grant_en), 32'(m_owner >= 0));
    chk("idx", 32'(o_grant_idx), 32'(m_idx));
    chk("grant", 32'(o_grant), m_owner >= 0 ? 32'(1) << m_owner : 32'(0));
    chk("busy", 32'(o_busy), 32'(m_owner >= 0 || m_gap));
    chk("onehot", 32'($countones(o_grant) <= 1), 32'(1));
  endtask
  task automatic wait_en(input int lim);
    for (int i = 0; i < lim && !o_grant_en; i++) step();
    chk("wait_en", 32'(o_grant_en), 32'(1));
  endtask
  task automatic do_reset();
    i_release = 1'b0;
    rst_n = 1'b0;
    #1;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #12;
    chk("rst_en", 32'(o_grant_en), 32'(0));
    chk("rst_idx", 32'(o_grant_idx), 32'(0));
    chk("rst_grant", 32'(o_grant), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    i_req = 16'h0001;
    step();
    chk("t1_grant", 32'(o_grant), 32'h0001);
    repeat (12) step();
    i_req = 16'h8001;
    repeat (40) step();
    do_reset();
    i_req = 16'hFFFF;
    repeat (3) step();
    i_release = 1'b1;
    step();
    chk("t3_drop", 32'(o_grant_en), 32'(0));
    i_release = 1'b0;
    repeat (2) step();
    chk("t3_idx", 32'(o_grant_idx), 32'(1));
    chk("t3_grant", 32'(o_grant), 32'h0002);
    do_reset();
    i_req = 16'h8000;
    wait_en(20);
    chk("t4_own15", 32'(o_grant_idx), 32'(15));
    i_req = 16'h4002;
    step();
    wait_en(5);
    chk("t4_idx1", 32'(o_grant_idx), 32'(1));
    repeat (8) step();
    wait_en(5);
    chk("t4_idx14", 32'(o_grant_idx), 32'(14));
    do_reset();
    i_req = 16'h0020;
    wait_en(5);
    step();
    i_req = 16'h0200;
    step();
    chk("t5_drop", 32'(o_grant_en), 32'(0));
    wait_en(5);
    chk("t5_idx", 32'(o_grant_idx), 32'(9));
    do_reset();
    i_req = 16'h0020;
    wait_en(5);
    chk("t6_pre", 32'(o_grant), 32'h0020);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_grant", 32'(o_grant), 32'(0));
    chk("t6_en", 32'(o_grant_en), 32'(0));
    chk("t6_busy", 32'(o_busy), 32'(0));
    m_reset();
    i_req = 16'h0024;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_idx", 32'(o_grant_idx), 32'(2));
    do_reset();
    repeat (3000) begin
      if ($urandom_range(3) == 0)
        i_req = $urandom_range(1) ? 16'($urandom) & 16'($urandom) : 16'(1 << $urandom_range(15)) | 16'(1 << $urandom_range(15));
      i_release = ($urandom_range(7) == 0);
      step();
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one resource among 16 requesters.
- Produces a registered 4-bit owner index plus enable, and the matching one-hot grant vector (a 4-to-16 decode gated by enable).
- Sits between 16 request sources and the shared resource's select/enable lines.
- Supports release by the owner, request withdrawal, and preemption after a maximum hold time.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16 in this revision.
- IDX_W, 4, index width; must equal log2(N_REQ).
- MAX_HOLD, 8, maximum cycles one owner keeps the grant before preemption; range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, 16, level request per requester; bit i = requester i.
- release, input, 1, current owner finished; sampled only in OWN.
- grant_idx, output, 4, index of the current owner; registered.
- grant_en, output, 1, a grant is valid; registered.
- grant, output, 16, one-hot grant = decode(grant_idx) AND grant_en; all zero when grant_en=0.
- busy, output, 1, high in OWN and GAP states.

Behaviour:
- Reset (async, while rst_n=0):
  - state=IDLE, grant_en=0, grant_idx=0, grant=0, busy=0, hold_cnt=0.
  - last_idx=15, so the first search starts at index 0.
- States: IDLE, OWN, GAP. Encoding constants live in the package.
- IDLE:
  - If req is nonzero, select the first set bit scanning last_idx+1, last_idx+2, ... modulo 16.
  - On the next edge: grant_idx=selected, grant_en=1, hold_cnt=0, state=OWN.
  - Latency: req rising to grant_en high is exactly 1 cycle.
  - If req=0, stay in IDLE with outputs held low.
- OWN:
  - hold_cnt increments once per cycle.
  - Exit when any of the following holds: (a) release=1; (b) req[grant_idx]=0; (c) hold_cnt==MAX_HOLD-1 (preempt). MAX_HOLD=N therefore gives exactly N cycles with grant_en high.
  - On exit, next edge: grant_en=0, last_idx=grant_idx, state=GAP. grant_idx holds its value.
  - Simultaneous exit conditions are a single exit event with identical behaviour.
  - release in IDLE or GAP is ignored.
- GAP:
  - Exactly one dead cycle with grant_en=0, guaranteeing no back-to-back ownership overlap at the resource.
  - Next edge: state=IDLE.
  - IDLE arbitrates in the same cycle, so the minimum spacing between two grants is 2 cycles of grant_en low.
- Fairness:
  - The pointer advances only on grant exit, so a continuously requesting owner cannot regain the grant while another requester is pending.
  - If the previous owner is the only requester, it is re-granted after GAP.
- Wrap-around: the scan wraps from index 15 to index 0; last_idx=15 makes index 0 the highest priority.
- Request changes: changes to req during OWN, other than the owner's own bit, have no effect until the next IDLE.
- Reset mid-operation: all outputs drop asynchronously on rst_n falling; no partial grant survives.
- Width rules: hold_cnt saturates logically via the exit condition and never wraps.

Decomposition:
- Package rr_arb_pkg holds:
  - state enum: IDLE=2'd0, OWN=2'd1, GAP=2'd2;
  - constants N_REQ and IDX_W;
  - a function for the rotate-and-priority-encode search.
- Sub-module onehot_dec16: combinational 4-to-16 decode with enable that drives the grant port. It is instantiated once; only the arbiter FSM is sequential.

Test Plan:
1. Reset, then req=16'h0001 held -> 1 cycle later grant_idx=0, grant_en=1, grant=16'h0001; grant drops after 8 cycles (MAX_HOLD=8); 1 GAP cycle; re-granted to 0.
2. req=16'h8001 held -> owner 0 for 8 cycles, GAP, owner 15 for 8 cycles, GAP, owner 0; grant never shows two bits set.
3. req=16'hFFFF, release pulsed on the 3rd cycle of owner 0 -> grant_en=0 on the following cycle, 1 GAP cycle, then grant_idx=1, grant=16'h0002.
4. Wrap: last owner 15, then req=16'h4002 -> next grant_idx=1, not 14; the grant after that is 14.
5. Owner 5 drops req[5] mid-grant while req[9]=1 -> grant_en=0 next cycle, GAP, then grant_idx=9.
6. rst_n asserted during OWN (grant=16'h0020) -> grant=0, grant_en=0, busy=0 immediately without a clock; after release with req=16'h0024, the first grant goes to index 2.
